// File: rtl/memory_bank_io_pkg.sv
// Shared address-map, scan-chain and flag-update helpers for memory_bank_io.
package memory_bank_io_pkg;

  function automatic int out_addr(input int mem_size, input int k);
    return mem_size + k;
  endfunction

  function automatic int stat_addr(input int mem_size, input int num_out);
    return mem_size + num_out;
  endfunction

  function automatic int edge_addr(input int mem_size, input int num_out);
    return mem_size + num_out + 1;
  endfunction

  function automatic int scan_len(input int mem_size, input int num_out,
                                  input int dw, input int num_in);
    return (mem_size + num_out) * dw + num_in;
  endfunction

  // A rise in the same cycle as a clear keeps the flag set.
  function automatic logic w1c_bit(input logic cur, input logic clr, input logic set);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/memory_bank_io_input_conditioner.sv
// Per-pin input path: 2-flop synchroniser, optional debouncer, rising-edge detector.
// Debouncer is built only when MEMORY_BANK_IO_DEBOUNCE_EN is defined.
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  input  logic hold,
  output logic level,
  output logic rise
);

  logic sync_p0, sync_p1;
  logic level_prev;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("io_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  // Synchroniser stage, keeps sampling even while scanning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
    end
  end

`ifdef MEMORY_BANK_IO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             filt;

  // Level filter stage: toggles on the DEBOUNCE_CYCLES-th consecutive differing cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (!hold) begin
      if (sync_p1 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt <= ~filt;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = filt;
`else
  assign level = sync_p1;
`endif

  // Edge-detect stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev <= 1'b0;
    end else begin
      level_prev <= level;
    end
  end

  assign rise = level & ~level_prev & ~hold;

endmodule

// File: rtl/memory_bank_io.sv
// Scan-loadable register file with memory-mapped output words, input status and W1C edge flags.
// Optional input debouncing is enabled with MEMORY_BANK_IO_DEBOUNCE_EN.
module memory_bank_io
  import memory_bank_io_pkg::*;
#(
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 8,
  parameter int MEM_SIZE        = 28,
  parameter int NUM_OUT         = 2,
  parameter int NUM_IN          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         data_out,
  input  logic                          scan_enable,
  input  logic                          scan_in,
  output logic                          scan_out,
  input  logic [NUM_IN-1:0]             in_pins,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_pins,
  output logic                          irq
);

  localparam int STAT_A   = stat_addr(MEM_SIZE, NUM_OUT);
  localparam int EDGE_A   = edge_addr(MEM_SIZE, NUM_OUT);
  localparam int CHAIN_L  = scan_len(MEM_SIZE, NUM_OUT, DATA_WIDTH, NUM_IN);
  localparam int RAM_BITS = MEM_SIZE * DATA_WIDTH;
  localparam int OUT_BITS = NUM_OUT * DATA_WIDTH;

  if ((2 ** ADDR_WIDTH) < MEM_SIZE + NUM_OUT + 2) begin : g_bad_addr
    $error("memory_bank_io: ADDR_WIDTH too small for the address map");
  end
  if (NUM_IN < 1 || NUM_IN > DATA_WIDTH) begin : g_bad_num_in
    $error("memory_bank_io: NUM_IN must be in 1..DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] ram      [MEM_SIZE];
  logic [DATA_WIDTH-1:0] out_word [NUM_OUT];
  logic [NUM_IN-1:0]     flags, flags_nxt, flag_clr;
  logic [NUM_IN-1:0]     level, rise;
  logic [CHAIN_L-1:0]    chain, chain_sh;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    io_input_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (in_pins[i]),
      .hold  (scan_enable),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Whole state as one vector; position 0 is nearest scan_in
  always_comb begin
    chain = '0;
    for (int i = 0; i < MEM_SIZE; i++) chain[i*DATA_WIDTH +: DATA_WIDTH] = ram[i];
    for (int k = 0; k < NUM_OUT; k++) chain[RAM_BITS + k*DATA_WIDTH +: DATA_WIDTH] = out_word[k];
    chain[RAM_BITS + OUT_BITS +: NUM_IN] = flags;
    chain_sh = {chain[CHAIN_L-2:0], scan_in};
  end

  always_comb begin
    flag_clr = '0;
    if (write_enable && address == ADDR_WIDTH'(EDGE_A)) flag_clr = data_in[NUM_IN-1:0];
    for (int j = 0; j < NUM_IN; j++) flags_nxt[j] = w1c_bit(flags[j], flag_clr[j], rise[j]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_SIZE; i++) ram[i] <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_word[k] <= '0;
      flags <= '0;
    end else if (scan_enable) begin
      for (int i = 0; i < MEM_SIZE; i++) ram[i] <= chain_sh[i*DATA_WIDTH +: DATA_WIDTH];
      for (int k = 0; k < NUM_OUT; k++)
        out_word[k] <= chain_sh[RAM_BITS + k*DATA_WIDTH +: DATA_WIDTH];
      flags <= chain_sh[RAM_BITS + OUT_BITS +: NUM_IN];
    end else begin
      for (int i = 0; i < MEM_SIZE; i++)
        if (write_enable && address == ADDR_WIDTH'(i)) ram[i] <= data_in;
      for (int k = 0; k < NUM_OUT; k++)
        if (write_enable && address == ADDR_WIDTH'(out_addr(MEM_SIZE, k))) out_word[k] <= data_in;
      flags <= flags_nxt;
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < MEM_SIZE; i++)
      if (address == ADDR_WIDTH'(i)) data_out = ram[i];
    for (int k = 0; k < NUM_OUT; k++)
      if (address == ADDR_WIDTH'(out_addr(MEM_SIZE, k))) data_out = out_word[k];
    if (address == ADDR_WIDTH'(STAT_A)) data_out[NUM_IN-1:0] = level;
    if (address == ADDR_WIDTH'(EDGE_A)) data_out[NUM_IN-1:0] = flags;
  end

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) out_pins[k*DATA_WIDTH +: DATA_WIDTH] = out_word[k];
  end

  assign scan_out = chain[CHAIN_L-1];
  assign irq      = |flags;

endmodule
